conv_inst_sequencer: RTL and testbench

// Hardware instruction sequencer for the core: generates the 34-bit inst bus for a full
// LEN_KI x LEN_KI convolution. Per kij: weights xmem->L0, kernel load into PEs, activations

---
 rtl/conv_inst_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_conv_inst_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_inst_sequencer.sv
// Instruction sequencer for the conv core: per-kij weight/activation
// staging, execute and OFIFO drain, followed by the pmem->SFP accumulation pass.
module conv_inst_sequencer #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int LEN_KI = 3,
    parameter int LEN_NI = 6,
    parameter int AW     = 11,
    parameter int W_BASE = 1024,
    parameter int KDRAIN = 16,
    parameter int XDRAIN = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          sfp_clr,
    output logic          out_valid,
    output logic [AW-1:0] out_idx,
    output logic [3:0]    kij_idx,
    output logic          busy,
    output logic          done
);

    localparam int LEN_KIJ  = LEN_KI * LEN_KI;
    localparam int LEN_NIJ  = LEN_NI * LEN_NI;
    localparam int LEN_ONI  = LEN_NI - LEN_KI + 1;
    localparam int LEN_ONIJ = LEN_ONI * LEN_ONI;

    if (LEN_KIJ * LEN_NIJ > (1 << AW) || W_BASE + LEN_KIJ * COL > (1 << AW) ||
        ROW < 1 || COL < 1 || LEN_KI < 1 || LEN_KI > LEN_NI || LEN_KIJ > 16 ||
        KDRAIN < 1 || XDRAIN < 1 || AW > 11) begin : g_bad_param
        $error("conv_inst_sequencer: parameter set does not fit");
    end

    typedef logic [15:0] cnt_t;

    localparam cnt_t C_COL     = cnt_t'(COL);
    localparam cnt_t C_COL_M1  = cnt_t'(COL - 1);
    localparam cnt_t C_KDR_M1  = cnt_t'(KDRAIN - 1);
    localparam cnt_t C_XDR_M1  = cnt_t'(XDRAIN - 1);
    localparam cnt_t C_NIJ     = cnt_t'(LEN_NIJ);
    localparam cnt_t C_NIJ_M1  = cnt_t'(LEN_NIJ - 1);
    localparam cnt_t C_KIJ     = cnt_t'(LEN_KIJ);
    localparam cnt_t C_KI_M1   = cnt_t'(LEN_KI - 1);
    localparam cnt_t C_ONI_M1  = cnt_t'(LEN_ONI - 1);

    localparam logic [AW-1:0] A_WB  = AW'(W_BASE);
    localparam logic [AW-1:0] A_COL = AW'(COL);
    localparam logic [AW-1:0] A_NIJ = AW'(LEN_NIJ);
    localparam logic [AW-1:0] A_KC  = AW'(LEN_NIJ + 1);
    localparam logic [AW-1:0] A_KR  = AW'(LEN_NIJ + LEN_NI - (LEN_KI - 1));
    localparam logic [AW-1:0] A_OR  = AW'(LEN_NI - (LEN_ONI - 1));
    localparam logic [AW-1:0] O_LAST = AW'(LEN_ONIJ - 1);
    localparam logic [3:0]    K_LAST = 4'(LEN_KIJ - 1);

    typedef struct packed {
        logic        acc;
        logic        cen_p;
        logic        wen_p;
        logic [10:0] a_p;
        logic        cen_x;
        logic        wen_x;
        logic [10:0] a_x;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam logic [33:0] RST_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_W2L0, S_KLOAD, S_KDR, S_A2L0, S_EXEC,
        S_XDR, S_OFRD, S_ACC, S_AOUT, S_ACLR, S_DONE
    } state_t;

    state_t        state;
    cnt_t          cnt;
    cnt_t          kc;
    cnt_t          ocol;
    logic [3:0]    kij;
    logic [AW-1:0] wbase;
    logic [AW-1:0] pbase;
    logic [AW-1:0] obase;
    logic [AW-1:0] kofs;
    logic [AW-1:0] o;

    inst_t d;
    logic  d_clr;
    logic  d_ov;
    logic  d_done;

    always_comb begin
        d       = inst_t'(RST_INST);
        d_clr   = 1'b0;
        d_ov    = 1'b0;
        d_done  = 1'b0;
        unique case (state)
            S_W2L0: begin
                if (cnt < C_COL) begin
                    d.cen_x = 1'b0;
                    d.a_x   = 11'(wbase + AW'(cnt));
                end
                d.l0_wr = (cnt != '0);
            end
            S_KLOAD: begin
                d.l0_rd = 1'b1;
                d.load  = 1'b1;
            end
            S_A2L0: begin
                if (cnt < C_NIJ) begin
                    d.cen_x = 1'b0;
                    d.a_x   = 11'(cnt);
                end
                d.l0_wr = (cnt != '0);
            end
            S_EXEC: begin
                d.l0_rd   = 1'b1;
                d.execute = 1'b1;
            end
            S_OFRD: begin
                if (ofifo_valid) begin
                    d.ofifo_rd = 1'b1;
                    d.cen_p    = 1'b0;
                    d.wen_p    = 1'b0;
                    d.a_p      = 11'(pbase + AW'(cnt));
                end
            end
            // pmem read data lands one cycle after its address
            S_ACC: begin
                if (cnt < C_KIJ) begin
                    d.cen_p = 1'b0;
                    d.a_p   = 11'(obase + kofs);
                end
                d.acc = (cnt != '0);
            end
            S_AOUT: d_ov = 1'b1;
            S_ACLR: d_clr = 1'b1;
            S_DONE: d_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kc        <= '0;
            ocol      <= '0;
            kij       <= '0;
            wbase     <= A_WB;
            pbase     <= '0;
            obase     <= '0;
            kofs      <= '0;
            o         <= '0;
            inst      <= RST_INST;
            sfp_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            kij_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= d;
            sfp_clr   <= d_clr;
            out_valid <= d_ov;
            done      <= d_done;
            out_idx   <= o;
            kij_idx   <= kij;
            busy      <= (state != S_IDLE) && (state != S_DONE);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_W2L0;
                        cnt   <= '0;
                        kij   <= '0;
                        wbase <= A_WB;
                        pbase <= '0;
                    end
                end
                S_W2L0: begin
                    if (cnt == C_COL) begin
                        state <= S_KLOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_KLOAD: begin
                    if (cnt == C_COL_M1) begin
                        state <= S_KDR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_KDR: begin
                    if (cnt == C_KDR_M1) begin
                        state <= S_A2L0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_A2L0: begin
                    if (cnt == C_NIJ) begin
                        state <= S_EXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt == C_NIJ_M1) begin
                        state <= S_XDR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_XDR: begin
                    if (cnt == C_XDR_M1) begin
                        state <= S_OFRD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OFRD: begin
                    if (ofifo_valid) begin
                        if (cnt == C_NIJ_M1) begin
                            cnt <= '0;
                            if (kij == K_LAST) begin
                                state <= S_ACC;
                                o     <= '0;
                                obase <= '0;
                                ocol  <= '0;
                                kofs  <= '0;
                                kc    <= '0;
                            end else begin
                                state <= S_W2L0;
                                kij   <= kij + 1'b1;
                                wbase <= wbase + A_COL;
                                pbase <= pbase + A_NIJ;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // kofs walks k*NIJ + (k/KI)*NI + k%KI using kc as the k%KI counter
                S_ACC: begin
                    if (cnt == C_KIJ) begin
                        state <= S_AOUT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (kc == C_KI_M1) begin
                            kc   <= '0;
                            kofs <= kofs + A_KR;
                        end else begin
                            kc   <= kc + 1'b1;
                            kofs <= kofs + A_KC;
                        end
                    end
                end
                S_AOUT: state <= S_ACLR;
                S_ACLR: begin
                    kofs <= '0;
                    kc   <= '0;
                    o    <= o + 1'b1;
                    if (ocol == C_ONI_M1) begin
                        ocol  <= '0;
                        obase <= obase + A_OR;
                    end else begin
                        ocol  <= ocol + 1'b1;
                        obase <= obase + 1'b1;
                    end
                    state <= (o == O_LAST) ? S_DONE : S_ACC;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Directed bench for conv_inst_sequencer: full 3x3/6x6 run, OFIFO stall,
// accumulation addressing, async reset mid-EXEC and a 1x1/4x4 build.
module tb_conv_inst_sequencer;

    localparam logic [33:0] RST_INST = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        sfp_clr;
    logic        out_valid;
    logic [10:0] out_idx;
    logic [3:0]  kij_idx;
    logic        busy;
    logic        done;

    logic        start2;
    logic [33:0] inst2;
    logic        sfp_clr2;
    logic        out_valid2;
    logic [10:0] out_idx2;
    logic [3:0]  kij_idx2;
    logic        busy2;
    logic        done2;

    always #5 clk = ~clk;

    conv_inst_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .sfp_clr(sfp_clr), .out_valid(out_valid),
        .out_idx(out_idx), .kij_idx(kij_idx), .busy(busy), .done(done)
    );

    conv_inst_sequencer #(.LEN_KI(1), .LEN_NI(4)) u_small (
        .clk(clk), .reset(reset), .start(start2), .ofifo_valid(1'b1),
        .inst(inst2), .sfp_clr(sfp_clr2), .out_valid(out_valid2),
        .out_idx(out_idx2), .kij_idx(kij_idx2), .busy(busy2), .done(done2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    bit mon_en = 1'b0;
    int cyc = 0;
    int xq[$];
    bit xrd, prev_xrd = 1'b0;
    bit pw, pr, prev_pr = 1'b0, prev_ov = 1'b0;
    int l0bad = 0, rdbad = 0, ififo_bad = 0, accbad = 0;
    int wr_cnt[324];
    int wr_oob = 0, wr_tot = 0, ap;
    int t117 = -1, t118 = -1;
    int acc_addr[16][9];
    int acc_cnt[16];
    int oc = 0, kc = 0;
    int ov_cnt = 0, ovbad = 0, clrbad = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            xrd = !inst[19];
            if (xrd) xq.push_back(int'(inst[17:7]));
            if (inst[2] != prev_xrd) l0bad++;
            prev_xrd = xrd;
            pw = !inst[32] && !inst[31];
            pr = !inst[32] && inst[31];
            if (inst[6] != pw) rdbad++;
            if (inst[5] || inst[4]) ififo_bad++;
            if (pw) begin
                ap = int'(inst[30:20]);
                wr_tot++;
                if (ap < 324) wr_cnt[ap]++;
                else wr_oob++;
                if (ap == 117) t117 = cyc;
                if (ap == 118) t118 = cyc;
            end
            if (inst[33] != prev_pr) accbad++;
            prev_pr = pr;
            if (pr) begin
                if (oc < 16 && kc < 9) acc_addr[oc][kc] = int'(inst[30:20]);
                kc++;
            end
            if (inst[33] && oc < 16) acc_cnt[oc]++;
            if (out_valid) begin
                ov_cnt++;
                if (int'(out_idx) != oc || kc != 9) ovbad++;
            end
            if (sfp_clr) begin
                if (!prev_ov) clrbad++;
                oc++;
                kc = 0;
            end
            prev_ov = out_valid;
            if (done) done_cnt++;
        end
    end

    int oc2 = 0, rd2 = 0, wr2 = 0, ov2 = 0, done2_cnt = 0, acc2bad = 0, accp2 = 0;

    always @(negedge clk) begin
        if (!inst2[32] && inst2[31]) begin
            if (int'(inst2[30:20]) != oc2) acc2bad++;
            rd2++;
        end
        if (!inst2[32] && !inst2[31]) wr2++;
        if (inst2[33]) accp2++;
        if (out_valid2) begin
            ov2++;
            oc2++;
        end
        if (done2) done2_cnt++;
    end

    typedef struct {
        int o;
        int k;
        int exp_ap;
    } vec_t;

    vec_t tbl[$];
    int   bad;
    bit   seen;

    initial begin
        tbl = '{
            '{5, 0, 7},   '{5, 1, 44},  '{5, 2, 81},
            '{5, 3, 121}, '{5, 4, 158}, '{5, 5, 195},
            '{5, 6, 235}, '{5, 7, 272}, '{5, 8, 309},
            '{0, 0, 0},   '{0, 3, 114}, '{0, 8, 302},
            '{4, 3, 120}, '{15, 0, 21}, '{15, 8, 323}
        };
        foreach (wr_cnt[i]) wr_cnt[i] = 0;
        foreach (acc_cnt[i]) acc_cnt[i] = 0;

        reset = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        ofifo_valid = 1'b1;
        #12;
        chk("rst_inst", inst, RST_INST);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sfp_clr", sfp_clr, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_kij_idx", kij_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        mon_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 chk("busy_after_start", busy, 1);

        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (t117 >= 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gap_reached", seen, 1);
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("kij_idx_gap", kij_idx, 3);
        repeat (2) @(negedge clk);
        ofifo_valid = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_reached", seen, 1);
        repeat (3) @(negedge clk);
        #1 chk("busy_after_done", busy, 0);
        mon_en = 1'b0;

        chk("xmem_reads", xq.size(), 396);
        if (xq.size() == 396) begin
            chk("xmem_first_w", xq[0], 1024);
            chk("xmem_last_w0", xq[7], 1031);
            chk("xmem_first_a", xq[8], 0);
            chk("xmem_last_a", xq[43], 35);
            chk("xmem_kij1_w", xq[44], 1032);
            bad = 0;
            for (int j = 0; j < 9; j++) begin
                for (int c = 0; c < 8; c++)
                    if (xq[j*44+c] != 1024 + j*8 + c) bad++;
                for (int c = 0; c < 36; c++)
                    if (xq[j*44+8+c] != c) bad++;
            end
            chk("xmem_seq_bad", bad, 0);
        end
        chk("l0_wr_lag_bad", l0bad, 0);
        chk("ififo_bits", ififo_bad, 0);
        chk("ofifo_rd_vs_wr", rdbad, 0);
        chk("pmem_wr_total", wr_tot, 324);
        chk("pmem_wr_oob", wr_oob, 0);
        bad = 0;
        foreach (wr_cnt[i]) if (wr_cnt[i] != 1) bad++;
        chk("pmem_wr_once", bad, 0);
        chk("gap_spacing", t118 - t117, 6);

        foreach (tbl[i])
            chk($sformatf("acc_ap_o%0d_k%0d", tbl[i].o, tbl[i].k),
                acc_addr[tbl[i].o][tbl[i].k], tbl[i].exp_ap);
        bad = 0;
        foreach (acc_cnt[i]) if (acc_cnt[i] != 9) bad++;
        chk("acc_len_bad", bad, 0);
        chk("acc_lag_bad", accbad, 0);
        chk("out_valid_cnt", ov_cnt, 16);
        chk("out_idx_bad", ovbad, 0);
        chk("clr_after_ov_bad", clrbad, 0);
        chk("clr_cnt", oc, 16);
        chk("done_cnt", done_cnt, 1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (inst[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("exec_reached", seen, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_inst", inst, RST_INST);
        chk("midrst_busy", busy, 0);
        chk("midrst_kij", kij_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("postrst_busy", busy, 0);
        chk("postrst_inst", inst, RST_INST);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (20) @(negedge clk);
        #1 chk("small_busy", busy2, 1);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (done2_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("small_done_reached", seen, 1);
        repeat (300) @(negedge clk);
        chk("small_done_cnt", done2_cnt, 1);
        chk("small_out_cnt", ov2, 16);
        chk("small_wr_cnt", wr2, 16);
        chk("small_acc_reads", rd2, 16);
        chk("small_acc_pulses", accp2, 16);
        chk("small_acc_addr_bad", acc2bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
